// File: rtl/count_seq_pkg.sv
// Shared constants, FSM state type and the wrap-around step rule for the
// mod-12 counter sequencer and its reference model.
package count_seq_pkg;

    localparam int MODULUS = 12;
    localparam int DATA_W  = 4;
    localparam int STEPS_W = 8;

    localparam logic [DATA_W-1:0] MAX_COUNT = DATA_W'(MODULUS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic [DATA_W-1:0] next_count(input logic [DATA_W-1:0] value,
                                                     input logic              dir);
        logic [DATA_W-1:0] nxt;
        if (dir) begin
            nxt = (value == MAX_COUNT) ? {DATA_W{1'b0}} : value + DATA_W'(1);
        end else begin
            nxt = (value == {DATA_W{1'b0}}) ? MAX_COUNT : value - DATA_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/count_ref_model.sv
// Registered reference counter: takes the start value on load_i, then advances
// one wrap-aware step per cycle while step_i is high.
module count_ref_model
    import count_seq_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_val_i,
    input  logic              step_i,
    input  logic              dir_i,
    output logic [DATA_W-1:0] exp_count_o
);

    logic [DATA_W-1:0] exp_q;

    // Expected-count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exp_q <= {DATA_W{1'b0}};
        end else if (load_i) begin
            exp_q <= load_val_i;
        end else if (step_i) begin
            exp_q <= next_count(exp_q, dir_i);
        end else begin
            exp_q <= exp_q;
        end
    end

    assign exp_count_o = exp_q;

endmodule

// File: rtl/count_cmd_sequencer.sv
// Command sequencer for the mod-12 up/down counter: loads, runs and checks it.
// Define CMD_SEQ_ERR_CNT_EN to add the saturating err_count output.
module count_cmd_sequencer
    import count_seq_pkg::*;
(
    input  logic               clock,
    input  logic               resetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_up_down,
    input  logic [DATA_W-1:0]  cmd_start,
    input  logic [STEPS_W-1:0] cmd_steps,
    output logic               load,
    output logic [DATA_W-1:0]  din,
    output logic               up_down,
    input  logic [DATA_W-1:0]  count,
    output logic               busy,
    output logic               done,
    output logic               mismatch,
`ifdef CMD_SEQ_ERR_CNT_EN
    output logic [7:0]         err_count,
`endif
    output logic [DATA_W-1:0]  exp_count
);

    state_e             state_q;
    logic               load_q;
    logic [DATA_W-1:0]  din_q;
    logic               up_down_q;
    logic               busy_q;
    logic               done_q;
    logic               mismatch_q;
    logic [STEPS_W-1:0] remaining_q;

    logic               accept_s;
    logic               cmp_fail_s;
    logic [DATA_W-1:0]  start_d;
    logic [DATA_W-1:0]  exp_count_s;

    assign cmd_ready = (state_q == IDLE) && resetn;
    assign accept_s  = cmd_valid && cmd_ready;

    // Out-of-range start values are replaced by zero.
    always_comb begin
        if (cmd_start >= DATA_W'(MODULUS)) begin
            start_d = {DATA_W{1'b0}};
        end else begin
            start_d = cmd_start;
        end
    end

    // The counter is only compared while a command is running or finishing.
    always_comb begin
        if ((state_q == RUN) || (state_q == DONE)) begin
            cmp_fail_s = (count != exp_count_s);
        end else begin
            cmp_fail_s = 1'b0;
        end
    end

    count_ref_model u_ref (
        .clk_i       (clock),
        .rst_ni      (resetn),
        .load_i      (state_q == LOAD),
        .load_val_i  (din_q),
        .step_i      (state_q == RUN),
        .dir_i       (up_down_q),
        .exp_count_o (exp_count_s)
    );

    // Command FSM with all counter-drive and status outputs registered.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            load_q      <= 1'b0;
            din_q       <= {DATA_W{1'b0}};
            up_down_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mismatch_q  <= 1'b0;
            remaining_q <= {STEPS_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        load_q      <= 1'b1;
                        din_q       <= start_d;
                        up_down_q   <= cmd_up_down;
                        remaining_q <= cmd_steps;
                        busy_q      <= 1'b1;
                        mismatch_q  <= 1'b0;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    load_q <= 1'b0;
                    if (remaining_q == {STEPS_W{1'b0}}) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    remaining_q <= remaining_q - STEPS_W'(1);
                    if (remaining_q == STEPS_W'(1)) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    load_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
            if (cmp_fail_s) begin
                mismatch_q <= 1'b1;
            end
        end
    end

`ifdef CMD_SEQ_ERR_CNT_EN
    logic [7:0] err_count_q;
    logic [7:0] err_count_d;

    // Saturating increment.
    always_comb begin
        if (err_count_q == 8'd255) begin
            err_count_d = err_count_q;
        end else begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // Failing-compare counter, restarted by each accepted command.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err_count_q <= 8'd0;
        end else if (accept_s) begin
            err_count_q <= 8'd0;
        end else if (cmp_fail_s) begin
            err_count_q <= err_count_d;
        end else begin
            err_count_q <= err_count_q;
        end
    end

    assign err_count = err_count_q;
`else
    // Without the error counter, divergence is reported by mismatch alone.
`endif

    assign load      = load_q;
    assign din       = din_q;
    assign up_down   = up_down_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mismatch  = mismatch_q;
    assign exp_count = exp_count_s;

endmodule

// File: doc/count_cmd_sequencer.md
Name: count_cmd_sequencer

Overview:
- Upstream stimulus stage for the mod-12 loadable up/down counter.
- Accepts run commands over a valid/ready handshake: start value, direction and step count.
- Drives the counter's load/din/up_down pins and reads back its count.
- Checks every counter value against an internal reference model and flags divergence.

Parameters:
MODULUS, 12, counter modulus; legal counts are 0..MODULUS-1
DATA_W, 4, width of din/count
STEPS_W, 8, width of step-count field

Ports:
clock  in  1  single clock, rising edge
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command
cmd_up_down  in  1  1 = count up, 0 = count down
cmd_start  in  DATA_W  value to load
cmd_steps  in  STEPS_W  number of count steps after the load
load  out  1  to counter: load din on next edge
din  out  DATA_W  to counter: load value
up_down  out  1  to counter: direction
count  in  DATA_W  from counter: current value
busy  out  1  command in progress
done  out  1  one-cycle pulse, command finished
mismatch  out  1  sticky: count differed from expected
exp_count  out  DATA_W  reference-model value

Behaviour:
- Reset (async, while resetn=0):
  - state=IDLE.
  - load=0, din=0, up_down=1.
  - busy=0, done=0, mismatch=0, exp_count=0.
  - cmd_ready=0.
- All outputs except cmd_ready are registered.
- cmd_ready = (state==IDLE) && resetn.
- Counter model: load=1 → count<=din. Otherwise up → (c==MODULUS-1 ? 0 : c+1); down → (c==0 ? MODULUS-1 : c-1). The counter counts every non-load cycle, including while the sequencer is idle.
- Handshake: a command is accepted at the edge where cmd_valid && cmd_ready (call it E0). cmd_valid may be held high; commands are not accepted while busy.
- Illegal start: cmd_start >= MODULUS is accepted, but din and the reference start both become 0.
- IDLE:
  - On accept: latch direction, start and steps; clear mismatch; load<=1, din<=start, up_down<=dir, busy<=1; go to LOAD.
  - up_down holds its last value while in IDLE.
  - No checking in IDLE.
- LOAD (exactly 1 cycle): at the next edge, load<=0, exp_count<=start, remaining<=steps.
  - steps==0 → go to DONE.
  - otherwise → go to RUN.
- RUN:
  - Each cycle, compare count to exp_count; on inequality set mismatch.
  - At each edge, exp_count<=next(exp_count) and remaining<=remaining-1.
  - When remaining==1 at an edge, go to DONE.
  - RUN lasts exactly `steps` cycles.
- DONE (1 cycle):
  - done=1, busy=1; perform a final compare.
  - At the next edge: done<=0, busy<=0, go to IDLE.
- Timing: done is high in the cycle starting at edge E(steps+1). Total comparisons = steps+1, covering the start value through the final value.
- Final expected value = (start ± steps) mod MODULUS. steps may exceed MODULUS; multiple wraps are allowed.
- mismatch is sticky until the next accepted command. A mismatch and a new accept can only be simultaneous in IDLE, where no check occurs.
- Reset mid-command: abort immediately to the reset values. No done pulse.

Optional Feature:
- Macro: CMD_SEQ_ERR_CNT_EN.
- Defined: adds output err_count [7:0].
  - Increments on every failing compare; saturates at 255.
  - Cleared on command accept and on reset.
- Undefined: the port and its logic are absent; mismatch behaviour is unchanged.

Decomposition:
- Package count_seq_pkg holds:
  - state enum {IDLE, LOAD, RUN, DONE};
  - MODULUS/width constants;
  - function next_count(value, dir) with the wrap rules.
- One sub-module, count_ref_model: a registered reference counter with load, step and exp_count output, instantiated by the sequencer.

Test Plan:
- Reset release; cmd start=3, up, steps=10 → 1-cycle load with din=3; count 3,4,…,11,0,1; exp_count=1; done at E11; mismatch=0.
- cmd start=1, down, steps=3 → count 1,0,11,10; done at E4; exp_count=10; mismatch=0.
- cmd start=7, steps=0 → LOAD then DONE; done at E1; count=7; busy high for exactly 2 cycles.
- Bench corrupts count to 5 for one RUN cycle where exp=4 → mismatch=1 and stays high through done; the next accepted command clears it (err_count=1 with CMD_SEQ_ERR_CNT_EN).
- cmd_valid held high with two queued commands → cmd_ready=0 while busy; second command accepted the cycle after DONE; no command lost or duplicated.
- resetn pulsed low mid-RUN of start=2, up, steps=20 → outputs reach reset values without waiting for a clock; no done pulse; state IDLE; cmd_ready=1 after release.
